// File: rtl/btn_led_ctrl_if.sv
// Button/LED bundle for btn_led_ctrl: raw buttons and mode in, debounced level, pulses and LEDs out.
// "release" is a reserved word in SystemVerilog, so the falling-edge pulse is carried as release_pulse.
interface btn_led_ctrl_if #(
  parameter int N = 2
);
  logic [N-1:0] btn;
  logic [N-1:0] mode;
  logic [N-1:0] stable;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;
  logic [N-1:0] led;

  modport master (
    output btn, mode,
    input  stable, press, release_pulse, led
  );

  modport slave (
    input  btn, mode,
    output stable, press, release_pulse, led
  );
endinterface

// File: rtl/btn_led_ctrl.sv
// N-channel button synchroniser/debouncer with press/release pulses and follow/toggle LED drive.
// Optional build macro BTN_ACTIVE_LOW_EN inverts the raw buttons (0 = pressed) ahead of the synchroniser.
module btn_led_ctrl #(
  parameter  int N         = 2,
  parameter  int DB_CYCLES = 50000,
  localparam int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input logic           clk,
  input logic           rst,
  btn_led_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic [N-1:0]     btn_in;
  logic [N-1:0]     s1;
  logic [N-1:0]     s0;
  logic [CNT_W-1:0] cnt [N];
  logic [N-1:0]     stable_q;
  logic [N-1:0]     press_q;
  logic [N-1:0]     release_q;
  logic [N-1:0]     led_q;
  logic [N-1:0]     stable_nxt;
  logic [N-1:0]     rise;
  logic [N-1:0]     fall;

`ifdef BTN_ACTIVE_LOW_EN
  assign btn_in = ~bus.btn;
`else
  assign btn_in = bus.btn;
`endif

  // A channel accepts the synchronised level only on the last cycle of an unbroken differing run.
  always_comb begin
    stable_nxt = stable_q;
    for (int i = 0; i < N; i++) begin
      if ((s0[i] != stable_q[i]) && (cnt[i] == LAST)) begin
        stable_nxt[i] = s0[i];
      end
    end
    rise = stable_nxt & ~stable_q;
    fall = ~stable_nxt & stable_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s0        <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      led_q     <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1        <= btn_in;
      s0        <= s1;
      stable_q  <= stable_nxt;
      press_q   <= rise;
      release_q <= fall;
      for (int i = 0; i < N; i++) begin
        if ((s0[i] == stable_q[i]) || (cnt[i] == LAST)) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
        // LED tracks the post-edge stable level in follow mode; toggle mode flips only on a rise.
        if (bus.mode[i]) begin
          led_q[i] <= led_q[i] ^ rise[i];
        end else begin
          led_q[i] <= stable_nxt[i];
        end
      end
    end
  end

  assign bus.stable        = stable_q;
  assign bus.press         = press_q;
  assign bus.release_pulse = release_q;
  assign bus.led           = led_q;

endmodule
